countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 51 +++++
 rtl/countdown_key_edge.sv | 30 +++
 rtl/sevenseg_decimal.sv | 24 ++
 rtl/countdown_timer.sv | 216 +++++++++++++++++++++
 tb/tb_countdown_timer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types, constants and time helpers for the countdown timer.
// Optional alarm blink is selected with COUNTDOWN_ALARM_BLINK_EN.
package countdown_pkg;

    localparam int unsigned TIME_W      = 19;
    localparam int unsigned MAX_CS      = 359999;
    localparam int unsigned CS_PER_MIN  = 6000;
    localparam int unsigned CS_PER_SEC  = 100;
    localparam int unsigned SEC_PER_MIN = 60;
    localparam int unsigned BLINK_TICKS = 50;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StExpired
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_units;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
        logic [3:0] cs_tens;
        logic [3:0] cs_units;
    } digits_t;

    function automatic logic [TIME_W-1:0] preset_cs(logic [5:0] mins, logic [5:0] secs);
        return TIME_W'(32'(mins) * CS_PER_MIN + 32'(secs) * CS_PER_SEC);
    endfunction

    function automatic digits_t split_time(logic [TIME_W-1:0] cs);
        int unsigned total;
        int unsigned mins;
        int unsigned secs;
        int unsigned cents;
        digits_t     d;
        total       = 32'(cs);
        mins        = total / CS_PER_MIN;
        secs        = (total / CS_PER_SEC) % SEC_PER_MIN;
        cents       = total % CS_PER_SEC;
        d.min_tens  = 4'(mins / 10);
        d.min_units = 4'(mins % 10);
        d.sec_tens  = 4'(secs / 10);
        d.sec_units = 4'(secs % 10);
        d.cs_tens   = 4'(cents / 10);
        d.cs_units  = 4'(cents % 10);
        return d;
    endfunction

endpackage

// File: rtl/countdown_key_edge.sv
// Two-flop synchronizer for an active-low key plus a falling-edge press pulse.
module countdown_key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Reset to the released level so no press appears right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        press = prev_q & ~sync2_q;
    end

endmodule

// File: rtl/sevenseg_decimal.sv
// Decimal digit to active-low seven-segment pattern (bit order gfedcba).
module sevenseg_decimal (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss.cc countdown timer with key presets, pause and expiry indication.
// Define COUNTDOWN_ALARM_BLINK_EN to blink the LEDs while expired.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_DIV = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key3,
    input  logic       key2,
    input  logic       key1,
    input  logic       key0,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic [9:0] led,
    output logic       expired
);

    localparam int unsigned PRESC_W = $clog2(CLK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic press3_raw, press2_raw, press1_raw, press0_raw;
    logic press3, press2, press1, press0;

    countdown_key_edge u_key3 (.clk(clk), .rst(rst), .key_n(key3), .press(press3_raw));
    countdown_key_edge u_key2 (.clk(clk), .rst(rst), .key_n(key2), .press(press2_raw));
    countdown_key_edge u_key1 (.clk(clk), .rst(rst), .key_n(key1), .press(press1_raw));
    countdown_key_edge u_key0 (.clk(clk), .rst(rst), .key_n(key0), .press(press0_raw));

    // Only the highest-priority press in a cycle survives.
    always_comb begin
        press3 = press3_raw;
        press2 = press2_raw & ~press3_raw;
        press1 = press1_raw & ~press3_raw & ~press2_raw;
        press0 = press0_raw & ~(press3_raw | press2_raw | press1_raw);
    end

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   remaining_q, remaining_d;
    logic [TIME_W-1:0]   preset;
    logic [TIME_W-1:0]   preset_load;
    logic [5:0]          preset_min_q, preset_min_d;
    logic [5:0]          preset_sec_q, preset_sec_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick;

    always_comb begin
        preset = preset_cs(preset_min_q, preset_sec_q);
        tick   = (presc_q == PRESC_LAST);
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        presc_d      = presc_q;
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;
        preset_load  = '0;
        case (state_q)
            StIdle: begin
                presc_d = '0;
                if (press3) begin
                    if (preset != '0) begin
                        state_d = StRun;
                    end
                end else if (press1) begin
                    preset_min_d = (preset_min_q == 6'd59) ? 6'd0 : preset_min_q + 6'd1;
                end else if (press0) begin
                    preset_sec_d = (preset_sec_q == 6'd59) ? 6'd0 : preset_sec_q + 6'd1;
                end
                preset_load = preset_cs(preset_min_d, preset_sec_d);
                remaining_d = (preset_load > TIME_W'(MAX_CS)) ? TIME_W'(MAX_CS) : preset_load;
            end
            StRun: begin
                if (press3) begin
                    state_d     = StIdle;
                    remaining_d = preset;
                    presc_d     = '0;
                end else if (press2) begin
                    state_d = StPause;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick && remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == TIME_W'(1)) begin
                            state_d = StExpired;
                        end
                    end
                end
            end
            StPause: begin
                if (press3) begin
                    state_d     = StIdle;
                    remaining_d = preset;
                    presc_d     = '0;
                end else if (press2) begin
                    state_d = StRun;
                end
            end
            StExpired: begin
                if (press3) begin
                    state_d     = StIdle;
                    remaining_d = preset;
                    presc_d     = '0;
                end else begin
                    // Keep ticking so the alarm pattern has a time base.
                    presc_d = tick ? '0 : presc_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            presc_q      <= '0;
            preset_min_q <= '0;
            preset_sec_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            presc_q      <= presc_d;
            preset_min_q <= preset_min_d;
            preset_sec_q <= preset_sec_d;
        end
    end

`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_TICKS);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q, blink_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (state_q != StExpired) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`endif

    digits_t    digits;
    logic [6:0] seg5, seg4, seg3, seg2, seg1, seg0;

    always_comb begin
        digits = split_time(remaining_q);
    end

    sevenseg_decimal u_dec5 (.digit(digits.min_tens),  .seg(seg5));
    sevenseg_decimal u_dec4 (.digit(digits.min_units), .seg(seg4));
    sevenseg_decimal u_dec3 (.digit(digits.sec_tens),  .seg(seg3));
    sevenseg_decimal u_dec2 (.digit(digits.sec_units), .seg(seg2));
    sevenseg_decimal u_dec1 (.digit(digits.cs_tens),   .seg(seg1));
    sevenseg_decimal u_dec0 (.digit(digits.cs_units),  .seg(seg0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex5 <= 7'b1000000;
            hex4 <= 7'b1000000;
            hex3 <= 7'b1000000;
            hex2 <= 7'b1000000;
            hex1 <= 7'b1000000;
            hex0 <= 7'b1000000;
        end else begin
            hex5 <= seg5;
            hex4 <= seg4;
            hex3 <= seg3;
            hex2 <= seg2;
            hex1 <= seg1;
            hex0 <= seg0;
        end
    end

    always_comb begin
        expired = (state_q == StExpired);
        led     = '0;
        case (state_q)
            StRun, StPause: led = 10'b1 << digits.sec_units;
`ifdef COUNTDOWN_ALARM_BLINK_EN
            StExpired:      led = blink_on_q ? 10'h3FF : 10'h000;
`else
            StExpired:      led = 10'h3FF;
`endif
            default:        led = '0;
        endcase
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboarded bench: a per-cycle reference model queues expected outputs.
`timescale 1ns/1ps
module tb_countdown_timer;

    localparam int unsigned CLK_DIV = 4;
    localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_EXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key3 = 1'b1, key2 = 1'b1, key1 = 1'b1, key0 = 1'b1;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic [9:0] led;
    logic       expired;

    countdown_timer #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .key3(key3), .key2(key2), .key1(key1), .key0(key0),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .led(led), .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        exp;
        logic [9:0]  led;
        logic [41:0] hex;
    } obs_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int         m_state, m_rem, m_preset, m_run, m_exp_ticks;
    logic [3:0] h3, h2, h1, h0;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] hex_of(int r);
        int m, s, c;
        m = r / 6000;
        s = (r / 100) % 60;
        c = r % 100;
        return {seg_of(m / 10), seg_of(m % 10), seg_of(s / 10), seg_of(s % 10),
                seg_of(c / 10), seg_of(c % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // Reference model: one step per rising edge, expected outputs queued.
    task automatic model_step();
        obs_t e;
        bit   p3, p2, p1, p0;
        int   old_rem;
        if (rst) begin
            m_state = ST_IDLE; m_rem = 0; m_preset = 0; m_run = 0; m_exp_ticks = 0;
            h3 = 4'hF; h2 = 4'hF; h1 = 4'hF; h0 = 4'hF;
            e.exp = 1'b0; e.led = '0; e.hex = hex_of(0);
            sb_q.push_back(e);
            return;
        end
        h3 = {h3[2:0], key3}; h2 = {h2[2:0], key2};
        h1 = {h1[2:0], key1}; h0 = {h0[2:0], key0};
        // A press acts two samples after the first low sample.
        p3 = !h3[2] && h3[3]; p2 = !h2[2] && h2[3];
        p1 = !h1[2] && h1[3]; p0 = !h0[2] && h0[3];
        if (p3) {p2, p1, p0} = 3'b000;
        else if (p2) {p1, p0} = 2'b00;
        else if (p1) p0 = 1'b0;
        old_rem = m_rem;
        case (m_state)
            ST_IDLE: begin
                if (p3) begin
                    if (m_preset != 0) begin m_state = ST_RUN; m_run = 0; end
                end else if (p1) begin
                    m_preset = ((m_preset / 6000 + 1) % 60) * 6000 + (m_preset / 100 % 60) * 100;
                end else if (p0) begin
                    m_preset = (m_preset / 6000) * 6000 + ((m_preset / 100 % 60 + 1) % 60) * 100;
                end
                m_rem = m_preset;
            end
            ST_RUN: begin
                if (p3) begin m_state = ST_IDLE; m_rem = m_preset; end
                else if (p2) m_state = ST_PAUSE;
                else begin
                    m_run++;
                    if (m_run % CLK_DIV == 0 && m_rem > 0) begin
                        m_rem--;
                        if (m_rem == 0) begin m_state = ST_EXP; m_exp_ticks = 0; end
                    end
                end
            end
            ST_PAUSE: begin
                if (p3) begin m_state = ST_IDLE; m_rem = m_preset; end
                else if (p2) m_state = ST_RUN;
            end
            default: begin
                if (p3) begin m_state = ST_IDLE; m_rem = m_preset; end
                else begin
                    m_run++;
                    if (m_run % CLK_DIV == 0) m_exp_ticks++;
                end
            end
        endcase
        e.exp = (m_state == ST_EXP);
        e.hex = hex_of(old_rem);
        if (m_state == ST_RUN || m_state == ST_PAUSE) e.led = 10'b1 << ((m_rem / 100) % 10);
        else if (m_state == ST_EXP) begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
            e.led = ((m_exp_ticks / 50) % 2 == 0) ? 10'h3FF : 10'h000;
`else
            e.led = 10'h3FF;
`endif
        end else e.led = '0;
        sb_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Monitor: every cycle presents an output, compared away from the edge.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check("scoreboard_underflow", 64'd0, 64'd1);
            end else begin
                e = sb_q.pop_front();
                check("expired", 64'(expired), 64'(e.exp));
                check("led", 64'(led), 64'(e.led));
                check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
            end
        end
    end

    task automatic press(input logic [3:0] mask, input int hold, input int gap);
        @(negedge clk);
        {key3, key2, key1, key0} = ~mask;
        repeat (hold) @(negedge clk);
        {key3, key2, key1, key0} = 4'hF;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rem(input int target, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (m_rem == target);
        end
        check(name, 64'(found), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(0)));
        check("reset_led", 64'(led), 64'd0);

        // Two minute presses, three second presses, then start.
        press(4'b0010, 2, 4); press(4'b0010, 2, 4);
        press(4'b0001, 2, 4); press(4'b0001, 2, 4); press(4'b0001, 2, 4);
        @(negedge clk); key3 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) key3 = 1'b1;
        end
        check("run_hex_020298", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({seg_of(0), seg_of(2), seg_of(0), seg_of(2), seg_of(9), seg_of(8)}));
        check("run_led_spot", 64'(led), 64'h004);
        press(4'b1000, 2, 6);

        // Preset 200 runs to expiry in 200 ticks.
        do_reset();
        press(4'b0001, 2, 4); press(4'b0001, 2, 4);
        @(negedge clk); key3 = 1'b0;
        n = 2000;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (i == 2) key3 = 1'b1;
            if (expired) begin n = i; break; end
        end
        check("expire_latency", 64'(n), 64'd803);
        @(posedge clk); #1;
        check("expired_hex_zero", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(0)));
        check("expired_led_start", 64'(led), 64'h3FF);
        repeat (249) @(posedge clk);
        #1;
`ifdef COUNTDOWN_ALARM_BLINK_EN
        check("expired_led_blink_off", 64'(led), 64'h000);
`else
        check("expired_led_steady", 64'(led), 64'h3FF);
`endif
        repeat (200) @(negedge clk);
        press(4'b1000, 2, 6);

        // Pause at 150 right after a tick, resume later.
        press(4'b1000, 2, 0);
        wait_rem(151, "reach_151");
        @(posedge clk); @(posedge clk);
        @(negedge clk); key2 = 1'b0;
        @(negedge clk); @(negedge clk); key2 = 1'b1;
        repeat (100) @(negedge clk);
        check("pause_hold_150", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({seg_of(0), seg_of(0), seg_of(0), seg_of(1), seg_of(5), seg_of(0)}));
        key2 = 1'b0;
        n = 50;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (i == 2) key2 = 1'b1;
            if (hex0 !== seg_of(0)) begin n = i; break; end
        end
        check("resume_latency", 64'(n), 64'd8);
        check("resume_digit", 64'(hex0), 64'(seg_of(9)));

        // Simultaneous stop and pause: stop wins.
        repeat (20) @(negedge clk);
        press(4'b1100, 2, 8);
        check("stop_wins_led", 64'(led), 64'd0);
        check("stop_wins_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(200)));

        // Reset asserted mid-run takes effect without a clock edge.
        press(4'b1000, 2, 0);
        wait_rem(77, "reach_77");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(0)));
        check("async_rst_led", 64'(led), 64'd0);
        check("async_rst_expired", 64'(expired), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        press(4'b1000, 2, 6);
        check("start_with_zero_preset", 64'(led), 64'd0);

        // Field wrap: 61 second presses then 60 minute presses leave 00:01.00.
        for (int i = 0; i < 61; i++) press(4'b0001, 1, 3);
        for (int i = 0; i < 60; i++) press(4'b0010, 1, 3);
        repeat (3) @(negedge clk);
        check("wrap_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_of(100)));

        // Randomized key activity against the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [3:0] mask;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    mask = 4'b0001;
                2, 3:    mask = 4'b0010;
                4:       mask = 4'b0100;
                5, 6:    mask = 4'b1000;
                7:       mask = 4'($urandom_range(1, 15));
                default: mask = 4'b0000;
            endcase
            press(mask, int'($urandom_range(1, 3)), int'($urandom_range(0, 40)));
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
